pic_int_seq: RTL and testbench

//  Interrupt sequencer between pic_top and the CPU core. Counts PIC int_o pulses, then runs the PIC
//  as a Wishbone master: OCW3 poll write, poll read, vector presentation, CPU acknowledge, EOI write.

---
 rtl/pic_int_seq.sv | 192 +++++++++++++++++++
 tb/tb_pic_int_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_int_seq.sv
// Interrupt sequencer: turns PIC int pulses into a held, vectored CPU request, polling the PIC
// over Wishbone (OCW3 poll write, poll read) and closing each interrupt with a nonspecific EOI.
module pic_int_seq #(
  parameter logic [31:0] PIC_BASE = 32'h0000_0000,
  parameter logic [7:0]  VEC_BASE = 8'h20,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pic_int_i,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  output logic        cpu_int_o,
  output logic [7:0]  cpu_vec_o,
  input  logic        cpu_iack_i,
  input  logic        cpu_eoi_i,
  output logic        busy_o,
  output logic        err_o,
  output logic        ovf_o
);

  localparam int unsigned      WaitW    = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
  localparam logic [31:0]      DatPoll  = 32'h0000_000C;
  localparam logic [31:0]      DatEoi   = 32'h0000_0020;

  typedef enum logic [2:0] {
    StIdle, StPollWr, StPollGap, StPollRd, StReq, StService, StEoiWr
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       pend_q, pend_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             cyc_q, cyc_d, we_q, we_d;
  logic [31:0]      dat_q, dat_d;
  logic             int_q, int_d;
  logic [7:0]       vec_q, vec_d;
  logic             err_q, err_d, ovf_q, ovf_d;
  logic             dec;
  logic             tmo;
  logic             unused_dat;

  assign unused_dat = ^m_dat_i[31:3];
  assign tmo        = cyc_q && !m_ack_i && (wait_q == WaitLast);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    dat_d   = dat_q;
    int_d   = int_q;
    vec_d   = vec_q;
    wait_d  = wait_q;
    err_d   = 1'b0;
    dec     = 1'b0;
    pend_d  = pend_q;
    ovf_d   = ovf_q;

    if (cyc_q && !m_ack_i && !tmo) wait_d = wait_q + 1'b1;

    case (state_q)
      StIdle: begin
        if (pend_q != 4'd0) begin
          state_d = StPollWr;
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          dat_d   = DatPoll;
          wait_d  = '0;
        end
      end
      StPollWr: begin
        if (m_ack_i) begin
          state_d = StPollGap;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          dat_d   = '0;
        end else if (tmo) begin
          state_d = StIdle;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          dat_d   = '0;
          err_d   = 1'b1;
          dec     = 1'b1;
        end
      end
      // One idle bus cycle between the poll write and the poll read.
      StPollGap: begin
        state_d = StPollRd;
        cyc_d   = 1'b1;
        wait_d  = '0;
      end
      StPollRd: begin
        if (m_ack_i) begin
          state_d = StReq;
          cyc_d   = 1'b0;
          vec_d   = VEC_BASE | {5'd0, m_dat_i[2:0]};
          int_d   = 1'b1;
          dec     = 1'b1;
        end else if (tmo) begin
          state_d = StIdle;
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          dec     = 1'b1;
        end
      end
      StReq: begin
        if (cpu_iack_i) begin
          state_d = StService;
          int_d   = 1'b0;
        end
      end
      StService: begin
        if (cpu_eoi_i) begin
          state_d = StEoiWr;
          cyc_d   = 1'b1;
          we_d    = 1'b1;
          dat_d   = DatEoi;
          wait_d  = '0;
        end
      end
      StEoiWr: begin
        if (m_ack_i || tmo) begin
          state_d = StIdle;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          dat_d   = '0;
          err_d   = !m_ack_i;
        end
      end
      default: begin
        state_d = StIdle;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        dat_d   = '0;
        int_d   = 1'b0;
      end
    endcase

    // Simultaneous pulse and consume cancel out.
    if (pic_int_i && !dec) begin
      if (pend_q == 4'hF) ovf_d = 1'b1;
      else                pend_d = pend_q + 4'd1;
    end else if (dec && !pic_int_i && pend_q != 4'd0) begin
      pend_d = pend_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      pend_q  <= '0;
      wait_q  <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      int_q   <= 1'b0;
      vec_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wait_q  <= wait_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      int_q   <= int_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign m_cyc_o   = cyc_q;
  assign m_stb_o   = cyc_q;
  assign m_we_o    = we_q;
  assign m_sel_o   = cyc_q ? 4'b0001 : 4'b0000;
  assign m_adr_o   = cyc_q ? PIC_BASE : 32'd0;
  assign m_dat_o   = dat_q;
  assign cpu_int_o = int_q;
  assign cpu_vec_o = vec_q;
  assign busy_o    = (state_q != StIdle);
  assign err_o     = err_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_pic_int_seq.sv
// Randomized scoreboard bench for pic_int_seq: a PIC slave responder, a CPU driver and a
// monitor that checks every bus cycle and vector against queued expectations.
module tb_pic_int_seq;

  localparam logic [31:0] PIC_BASE = 32'h0000_4000;
  localparam logic [7:0]  VEC_BASE = 8'h20;
  localparam int unsigned TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        rst_i, pic_int_i, m_ack_i;
  logic [31:0] m_dat_i;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic        cpu_int_o, busy_o, err_o, ovf_o;
  logic [7:0]  cpu_vec_o;
  logic        cpu_iack_i, cpu_eoi_i;
  logic        auto_iack, auto_eoi, man_iack, man_eoi;

  assign cpu_iack_i = auto_iack | man_iack;
  assign cpu_eoi_i  = auto_eoi | man_eoi;

  pic_int_seq #(.PIC_BASE(PIC_BASE), .VEC_BASE(VEC_BASE), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i), .pic_int_i(pic_int_i),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .cpu_int_o(cpu_int_o), .cpu_vec_o(cpu_vec_o), .cpu_iack_i(cpu_iack_i),
    .cpu_eoi_i(cpu_eoi_i), .busy_o(busy_o), .err_o(err_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] dat;
  } bus_t;

  bus_t       exp_bus[$];
  logic [7:0] exp_vec[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         err_cnt = 0;
  bit         stall_wr = 0, stall_rd = 0, rand_wait = 0, cpu_auto = 0;
  int         force_code = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_bus(input logic we, input logic [31:0] dat);
    bus_t e;
    e.we  = we;
    e.dat = dat;
    exp_bus.push_back(e);
  endfunction

  // Every serviced interrupt: poll write, poll read, then EOI write.
  function automatic void push_seq();
    push_bus(1'b1, 32'h0C);
    push_bus(1'b0, 32'h00);
    push_bus(1'b1, 32'h20);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    pic_int_i = 1'b1;
    tick();
    pic_int_i = 1'b0;
  endtask

  task automatic wait_int(input string name);
    int n = 0;
    while (!cpu_int_o && n < 100) begin
      tick();
      n++;
    end
    check({name, "_int_seen"}, cpu_int_o, 1);
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while ((busy_o || exp_bus.size() != 0 || exp_vec.size() != 0) && n < max) begin
      tick();
      n++;
    end
    check({name, "_drained"}, busy_o || exp_bus.size() != 0 || exp_vec.size() != 0, 0);
    repeat (20) tick();
  endtask

  // PIC slave: acks after a few wait states, returns a random code on poll reads.
  initial begin
    int          wcnt = 0;
    int          target = 0;
    logic [2:0]  code;
    logic [31:0] r;
    m_ack_i = 1'b0;
    m_dat_i = '0;
    forever begin
      tick();
      m_ack_i = 1'b0;
      m_dat_i = $urandom;
      if (rst_i) begin
        wcnt = 0;
      end else if (m_cyc_o && !(m_we_o ? stall_wr : stall_rd)) begin
        if (wcnt >= target) begin
          m_ack_i = 1'b1;
          wcnt    = 0;
          target  = rand_wait ? $urandom_range(0, 3) : 0;
          if (!m_we_o) begin
            code    = (force_code >= 0) ? force_code[2:0] : 3'($urandom_range(0, 7));
            r       = $urandom;
            r[2:0]  = code;
            m_dat_i = r;
            exp_vec.push_back(VEC_BASE | {5'd0, code});
          end
        end else begin
          wcnt++;
        end
      end else if (!m_cyc_o && rand_wait && $urandom_range(0, 7) == 0) begin
        m_ack_i = 1'b1;
      end
    end
  end

  // CPU: acknowledges then ends each interrupt, toggling the other strobe where it is ignored.
  initial begin
    auto_iack = 1'b0;
    auto_eoi  = 1'b0;
    forever begin
      tick();
      if (cpu_auto && cpu_int_o) begin
        repeat ($urandom_range(0, 3)) tick();
        auto_iack = 1'b1;
        auto_eoi  = 1'($urandom_range(0, 1));
        tick();
        auto_iack = 1'b0;
        auto_eoi  = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        auto_eoi  = 1'b1;
        auto_iack = 1'($urandom_range(0, 1));
        tick();
        auto_iack = 1'b0;
        auto_eoi  = 1'b0;
      end
    end
  end

  // Monitor: pops expectations when a bus cycle starts or the CPU request rises.
  initial begin
    logic       prev_cyc = 1'b0, prev_int = 1'b0, prev_err = 1'b0;
    bus_t       cur = '0;
    bus_t       e;
    logic [7:0] cur_vec = '0;
    forever begin
      @(negedge clk);
      if (m_cyc_o && !prev_cyc) begin
        check("bus_cycle_expected", exp_bus.size() != 0, 1);
        if (exp_bus.size() != 0) begin
          e = exp_bus.pop_front();
          check("bus_we", m_we_o, e.we);
          check("bus_dat", m_dat_o, e.dat);
          check("bus_adr", m_adr_o, PIC_BASE);
          check("bus_sel", m_sel_o, 4'b0001);
        end
        cur.we  = m_we_o;
        cur.dat = m_dat_o;
      end
      if (m_cyc_o)
        check("bus_stable", m_stb_o && m_we_o == cur.we && m_dat_o == cur.dat &&
              m_adr_o == PIC_BASE && m_sel_o == 4'b0001, 1);
      else
        check("bus_idle_zero", m_stb_o | m_we_o | (|m_sel_o) | (|m_adr_o) | (|m_dat_o), 0);
      if (cpu_int_o && !prev_int) begin
        check("vec_expected", exp_vec.size() != 0, 1);
        if (exp_vec.size() != 0) begin
          cur_vec = exp_vec.pop_front();
          check("cpu_vec", cpu_vec_o, cur_vec);
        end
      end else if (cpu_int_o) begin
        check("vec_held", cpu_vec_o, cur_vec);
      end
      if (err_o) begin
        err_cnt++;
        check("err_single_cycle", prev_err, 0);
      end
      prev_cyc = m_cyc_o;
      prev_int = cpu_int_o;
      prev_err = err_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int e0;
    int n;
    rst_i     = 1'b1;
    pic_int_i = 1'b0;
    man_iack  = 1'b0;
    man_eoi   = 1'b0;
    repeat (2) tick();
    check("rst_cyc", m_cyc_o, 0);
    check("rst_int", cpu_int_o, 0);
    check("rst_vec", cpu_vec_o, 0);
    check("rst_busy_err_ovf", {busy_o, err_o, ovf_o}, 0);
    rst_i = 1'b0;
    tick();

    // Single pulse, zero-wait acks, code 3: request must appear exactly five edges later.
    push_seq();
    pulse();
    check("t1_int_e1", cpu_int_o, 0);
    tick();
    check("t1_pollwr_e2", {m_cyc_o, m_we_o, m_dat_o[7:0]}, {2'b11, 8'h0C});
    tick();
    check("t1_gap_e3", m_cyc_o, 0);
    tick();
    check("t1_pollrd_e4", {m_cyc_o, m_we_o, cpu_int_o}, 3'b100);
    tick();
    check("t1_int_e5", cpu_int_o, 1);
    check("t1_vec_e5", cpu_vec_o, 8'h23);
    cpu_auto = 1;
    wait_idle(100, "t1");
    check("t1_busy_low", busy_o, 0);

    // Three pulses landing during one sequence.
    force_code = -1;
    e0 = err_cnt;
    for (int i = 0; i < 3; i++) begin
      push_seq();
      pulse();
      repeat (2) tick();
    end
    wait_idle(300, "t2");
    check("t2_no_err", err_cnt - e0, 0);

    // Random bursts with random wait states and stray acks.
    rand_wait = 1;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        push_seq();
        pulse();
        repeat ($urandom_range(0, 12)) tick();
      end
      wait_idle(1000, "rand");
    end
    rand_wait = 0;

    // Stalled bus: 16 back-to-back pulses saturate at 15, each pending poll write times out.
    stall_wr = 1;
    stall_rd = 1;
    e0 = err_cnt;
    for (int i = 0; i < 15; i++) push_bus(1'b1, 32'h0C);
    check("t3_ovf_before", ovf_o, 0);
    pic_int_i = 1'b1;
    repeat (16) tick();
    pic_int_i = 1'b0;
    check("t3_ovf_set", ovf_o, 1);
    wait_idle(400, "t3");
    check("t3_err_count", err_cnt - e0, 15);
    check("t3_ovf_sticky", ovf_o, 1);
    stall_wr = 0;
    stall_rd = 0;

    // Poll read never acked: bus held TIMEOUT cycles, one err pulse, pending consumed.
    stall_rd = 1;
    e0 = err_cnt;
    push_bus(1'b1, 32'h0C);
    push_bus(1'b0, 32'h00);
    pulse();
    n = 0;
    while (!(m_cyc_o && !m_we_o) && n < 50) begin
      tick();
      n++;
    end
    check("t4_rd_started", m_cyc_o && !m_we_o, 1);
    n = 0;
    while (m_cyc_o && n < 100) begin
      tick();
      n++;
    end
    check("t4_rd_cycles", n, TIMEOUT);
    check("t4_err_high", err_o, 1);
    check("t4_busy_low", busy_o, 0);
    tick();
    check("t4_err_low", err_o, 0);
    stall_rd = 0;
    wait_idle(50, "t4");
    check("t4_err_count", err_cnt - e0, 1);

    // EOI during REQ and IACK during SERVICE are ignored.
    cpu_auto   = 0;
    force_code = 5;
    tick();
    push_seq();
    pulse();
    wait_int("t5");
    man_eoi = 1'b1;
    repeat (3) tick();
    man_eoi = 1'b0;
    check("t5_eoi_in_req", {cpu_int_o, busy_o, m_cyc_o}, 3'b110);
    check("t5_vec", cpu_vec_o, 8'h25);
    man_iack = 1'b1;
    tick();
    man_iack = 1'b0;
    check("t5_iack_drops_int", cpu_int_o, 0);
    man_iack = 1'b1;
    repeat (3) tick();
    man_iack = 1'b0;
    check("t5_iack_in_service", {busy_o, m_cyc_o}, 2'b10);
    man_eoi = 1'b1;
    tick();
    man_eoi = 1'b0;
    check("t5_eoi_write", {m_cyc_o, m_we_o, m_dat_o[7:0]}, {2'b11, 8'h20});
    wait_idle(50, "t5");

    // Reset during a stalled EOI write, with two more pulses pending.
    force_code = -1;
    check("t6_ovf_still_set", ovf_o, 1);
    push_seq();
    pulse();
    wait_int("t6");
    man_iack = 1'b1;
    tick();
    man_iack = 1'b0;
    pulse();
    tick();
    pulse();
    stall_wr = 1;
    man_eoi  = 1'b1;
    tick();
    man_eoi  = 1'b0;
    check("t6_eoi_cyc", {m_cyc_o, m_we_o}, 2'b11);
    repeat (2) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    stall_wr = 0;
    check("t6_rst_bus", {m_cyc_o, m_stb_o}, 2'b00);
    check("t6_rst_int_busy", {cpu_int_o, busy_o}, 2'b00);
    check("t6_rst_ovf", ovf_o, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m_cyc_o) n++;
    end
    check("t6_no_bus_after_rst", n, 0);
    check("t6_queue_empty", exp_bus.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
